dcmac_serdes_reset_seq: RTL and testbench

// - Sequences GT/serdes bring-up for the 6-lane DCMAC serdes clock bundle (lanes 0,1 driven from usrclk, 2..5 tied off).
// - Pulses GT reset, waits for per-lane reset-done on enabled lanes, lets clocks settle, then releases per-lane serdes resets.
// - Retries on timeout or loss of lock; flags a sticky error after MAX_RETRY failed attempts.
// - Sits between platform reset logic and the DCMAC/GT wrapper in the same usrclk domain.

---
 rtl/dcmac_seq_pkg.sv | 32 +++
 rtl/dcmac_seq_timer.sv | 32 +++
 rtl/dcmac_serdes_reset_seq.sv | 138 +++++++++++++
 tb/tb_dcmac_serdes_reset_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcmac_seq_pkg.sv
// Shared types and default constants for the DCMAC serdes reset sequencer.
//   seq_state_e      : sequencer states
//   NUM_SERDES_LANES : lanes in the serdes clock bundle
//   DEF_*            : default cycle counts and retry limit
//   max3             : largest of three values, used to size the shared counter
package dcmac_seq_pkg;

    localparam int unsigned NUM_SERDES_LANES   = 6;
    localparam int unsigned DEF_RST_CYCLES     = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_SETTLE_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRY      = 3;
    localparam int unsigned ATTEMPT_W          = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PWR_WAIT  = 3'd1,
        GT_RST    = 3'd2,
        DONE_WAIT = 3'd3,
        SETTLE    = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dcmac_seq_timer.sv
// Loadable down-counter with a registered expired flag.
//   clk, rst_n : clock and async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value loaded; the counter then spends load_val+1 cycles before expiring
//   expired    : high while the count is zero
module dcmac_seq_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Count down to zero and hold; expired tracks the next count value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            expired <= 1'b1;
        end else if (load) begin
            count   <= load_val;
            expired <= (load_val == '0);
        end else if (count != '0) begin
            count   <= count - WIDTH'(1);
            expired <= (count == WIDTH'(1));
        end
    end

endmodule

// File: rtl/dcmac_serdes_reset_seq.sv
// GT/serdes bring-up sequencer for the DCMAC serdes clock bundle.
//   usrclk, aresetn : clock and async active-low reset
//   start           : 1-cycle start pulse (accepted in IDLE, RUN, FAIL)
//   lane_mask       : enabled lanes, latched on an accepted start
//   gt_pwr_good     : GT power good
//   gt_reset_done   : per-lane GT reset done
//   gt_reset        : GT reset, active-high
//   serdes_rst      : per-lane serdes reset, active-high
//   busy, link_up   : sequence in progress / link running
//   error           : sticky failure flag, cleared by an accepted start
//   attempts        : failed attempts in the current sequence (saturating)
module dcmac_serdes_reset_seq
    import dcmac_seq_pkg::*;
#(
    parameter int unsigned NUM_LANES      = NUM_SERDES_LANES,
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic                 usrclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic                 gt_pwr_good,
    input  logic [NUM_LANES-1:0] gt_reset_done,
    output logic                 gt_reset,
    output logic [NUM_LANES-1:0] serdes_rst,
    output logic                 busy,
    output logic                 link_up,
    output logic                 error,
    output logic [ATTEMPT_W-1:0] attempts
);

    localparam int unsigned CNT_MAX = max3(RST_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ATTEMPT_W-1:0] ATT_LIMIT = ATTEMPT_W'(MAX_RETRY);
    localparam logic [ATTEMPT_W-1:0] ATT_SAT   = '1;

    seq_state_e           state_q, state_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [ATTEMPT_W-1:0] attempts_d, att_inc;
    logic                 error_d, gt_reset_d, busy_d, link_up_d;
    logic [NUM_LANES-1:0] serdes_rst_d;
    logic                 start_ok, all_done, fail_try;
    logic                 tmr_load, tmr_expired;
    logic [CNT_W-1:0]     tmr_val;

    dcmac_seq_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (usrclk),
        .rst_n    (aresetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next state, bookkeeping and next output values.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        attempts_d = attempts;
        error_d    = error;
        fail_try   = 1'b0;
        tmr_val    = '0;
        start_ok   = start && (state_q inside {IDLE, RUN, FAIL});
        all_done   = ((gt_reset_done & mask_q) == mask_q);
        att_inc    = (attempts == ATT_SAT) ? attempts : attempts + ATTEMPT_W'(1);

        if (start_ok) begin
            mask_d     = lane_mask;
            attempts_d = '0;
            error_d    = 1'b0;
            state_d    = (lane_mask == '0) ? FAIL : PWR_WAIT;
        end else if (!gt_pwr_good && !(state_q inside {IDLE, FAIL})) begin
            state_d = PWR_WAIT;
        end else begin
            case (state_q)
                PWR_WAIT:  state_d = GT_RST;
                GT_RST:    if (tmr_expired) state_d = DONE_WAIT;
                // Done is checked before the timeout so a coincident done wins.
                DONE_WAIT: begin
                    if (all_done)         state_d  = SETTLE;
                    else if (tmr_expired) fail_try = 1'b1;
                end
                SETTLE: begin
                    if (!all_done)        fail_try = 1'b1;
                    else if (tmr_expired) state_d  = RUN;
                end
                // Lock loss is a relock, not a failed attempt.
                RUN:       if (!all_done) state_d = GT_RST;
                default:   ;
            endcase
        end

        if (fail_try) begin
            attempts_d = att_inc;
            state_d    = (att_inc >= ATT_LIMIT) ? FAIL : GT_RST;
        end
        if (state_d == FAIL) error_d = 1'b1;

        case (state_d)
            GT_RST:    tmr_val = CNT_W'(RST_CYCLES - 1);
            DONE_WAIT: tmr_val = CNT_W'(TIMEOUT_CYCLES - 1);
            SETTLE:    tmr_val = CNT_W'(SETTLE_CYCLES - 1);
            default:   tmr_val = '0;
        endcase
        tmr_load = (state_d != state_q);

        gt_reset_d   = (state_d == GT_RST);
        link_up_d    = (state_d == RUN);
        busy_d       = !(state_d inside {IDLE, RUN, FAIL});
        serdes_rst_d = (state_d == RUN) ? ~mask_d : '1;
    end

    // State and registered outputs, all updated together.
    always_ff @(posedge usrclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            attempts   <= '0;
            error      <= 1'b0;
            gt_reset   <= 1'b0;
            serdes_rst <= '1;
            busy       <= 1'b0;
            link_up    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            attempts   <= attempts_d;
            error      <= error_d;
            gt_reset   <= gt_reset_d;
            serdes_rst <= serdes_rst_d;
            busy       <= busy_d;
            link_up    <= link_up_d;
        end
    end

endmodule

// File: tb/tb_dcmac_serdes_reset_seq.sv
// Self-checking bench for dcmac_serdes_reset_seq with a phase/age reference model.
module tb_dcmac_serdes_reset_seq;

    localparam int RST_C = 16;
    localparam int TO_C  = 256;
    localparam int ST_C  = 1024;
    localparam int MAXR  = 3;

    localparam int P_IDLE = 0, P_PWR = 1, P_RST = 2, P_WAIT = 3, P_SET = 4, P_RUN = 5, P_FAIL = 6;
    localparam logic [13:0] RESET_VEC = {1'b0, 6'h3F, 1'b0, 1'b0, 1'b0, 4'h0};

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic [5:0] lane_mask = 6'h0;
    logic       gt_pwr_good = 1'b1;
    logic [5:0] gt_reset_done = 6'h0;
    logic       gt_reset, busy, link_up, error;
    logic [5:0] serdes_rst;
    logic [3:0] attempts;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dcmac_serdes_reset_seq #(
        .NUM_LANES(6), .RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C),
        .SETTLE_CYCLES(ST_C), .MAX_RETRY(MAXR)
    ) dut (
        .usrclk(clk), .aresetn(aresetn), .start(start), .lane_mask(lane_mask),
        .gt_pwr_good(gt_pwr_good), .gt_reset_done(gt_reset_done),
        .gt_reset(gt_reset), .serdes_rst(serdes_rst), .busy(busy),
        .link_up(link_up), .error(error), .attempts(attempts)
    );

    // Reference model: current phase plus cycles spent in it (counting up).
    int         m_phase, m_age, m_att, n_phase, n_age, n_att;
    logic [5:0] m_mask, n_mask;
    logic       m_err, n_err, n_fail, m_ok;
    logic [13:0] m_vec, dut_vec;

    always_comb begin
        n_phase = m_phase; n_age = m_age; n_att = m_att; n_mask = m_mask; n_err = m_err;
        n_fail  = 1'b0;
        m_ok    = ((gt_reset_done & m_mask) == m_mask);
        if (start && (m_phase == P_IDLE || m_phase == P_RUN || m_phase == P_FAIL)) begin
            n_mask = lane_mask; n_att = 0; n_err = 1'b0; n_age = 0;
            n_phase = (lane_mask == 6'h0) ? P_FAIL : P_PWR;
        end else if (!gt_pwr_good && m_phase != P_IDLE && m_phase != P_FAIL) begin
            n_phase = P_PWR; n_age = 0;
        end else begin
            case (m_phase)
                P_PWR: begin n_phase = P_RST; n_age = 0; end
                P_RST: if (m_age + 1 == RST_C) begin n_phase = P_WAIT; n_age = 0; end
                       else n_age = m_age + 1;
                P_WAIT: if (m_ok) begin n_phase = P_SET; n_age = 0; end
                        else if (m_age + 1 == TO_C) n_fail = 1'b1;
                        else n_age = m_age + 1;
                P_SET: if (!m_ok) n_fail = 1'b1;
                       else if (m_age + 1 == ST_C) begin n_phase = P_RUN; n_age = 0; end
                       else n_age = m_age + 1;
                P_RUN: if (!m_ok) begin n_phase = P_RST; n_age = 0; end
                default: ;
            endcase
        end
        if (n_fail) begin
            n_att   = (m_att < 15) ? m_att + 1 : 15;
            n_phase = (n_att >= MAXR) ? P_FAIL : P_RST;
            n_age   = 0;
        end
        if (n_phase == P_FAIL) n_err = 1'b1;
        m_vec = {m_phase == P_RST, (m_phase == P_RUN) ? ~m_mask : 6'h3F,
                 !(m_phase == P_IDLE || m_phase == P_RUN || m_phase == P_FAIL),
                 m_phase == P_RUN, m_err, 4'(m_att)};
        dut_vec = {gt_reset, serdes_rst, busy, link_up, error, attempts};
    end

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_phase <= P_IDLE; m_age <= 0; m_att <= 0; m_mask <= 6'h0; m_err <= 1'b0;
        end else begin
            m_phase <= n_phase; m_age <= n_age; m_att <= n_att; m_mask <= n_mask; m_err <= n_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; start is seen by exactly one rising edge.
    task automatic pulse_start(input logic [5:0] m);
        lane_mask = m; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_link(input int limit);
        int n = 0;
        while (!link_up && n < limit) begin tick(1); n++; end
    endtask

    task automatic test_reset;
        tick(2);
        total++; if (dut_vec !== RESET_VEC) $display("FAIL reset_vals: got %h want %h", dut_vec, RESET_VEC); else passed++;
        aresetn = 1'b1;
        tick(3);
        total++; if (dut_vec !== m_vec) $display("FAIL reset_idle: got %h want %h", dut_vec, m_vec); else passed++;
        total++; if (serdes_rst !== 6'h3F) $display("FAIL idle_serdes: got %h want 3f", serdes_rst); else passed++;
    endtask

    task automatic test_nominal;
        int n = 0, w = 0;
        gt_reset_done = 6'h00;
        pulse_start(6'h03);
        while (!gt_reset && n < 50) begin tick(1); n++; end
        while (gt_reset && w < 100) begin tick(1); w++; end
        total++; if (w !== RST_C) $display("FAIL nom_rst_width: got %0d want %0d", w, RST_C); else passed++;
        tick(100);
        gt_reset_done = 6'h03;
        n = 0;
        while (!link_up && n < 3000) begin tick(1); n++; end
        // One edge into SETTLE, then SETTLE_CYCLES cycles in it.
        total++; if (n !== ST_C + 1) $display("FAIL nom_settle_len: got %0d want %0d", n, ST_C + 1); else passed++;
        total++; if (serdes_rst !== 6'h3C) $display("FAIL nom_serdes: got %h want 3c", serdes_rst); else passed++;
        total++; if (attempts !== 4'd0 || busy !== 1'b0) $display("FAIL nom_att_busy: got %0d/%b want 0/0", attempts, busy); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL nom_model: got %h want %h", dut_vec, m_vec); else passed++;
    endtask

    task automatic test_timeout;
        int pulses = 0, cur = 0, gap = 0, n = 0;
        int widths[$], gaps[$], att_at[$];
        logic prev = 1'b0;
        gt_reset_done = 6'h00;
        pulse_start(6'h03);
        while (!error && n < 3000) begin
            if (gt_reset && !prev) begin
                pulses++; att_at.push_back(int'(attempts));
                if (pulses > 1) gaps.push_back(gap);
            end
            if (gt_reset) cur++;
            else begin
                if (prev) begin widths.push_back(cur); cur = 0; gap = 0; end
                gap++;
            end
            prev = gt_reset;
            tick(1); n++;
        end
        total++; if (pulses !== 3) $display("FAIL to_pulses: got %0d want 3", pulses); else passed++;
        for (int i = 0; i < widths.size(); i++) begin
            total++; if (widths[i] !== RST_C) $display("FAIL to_width%0d: got %0d want %0d", i, widths[i], RST_C); else passed++;
        end
        for (int i = 0; i < att_at.size(); i++) begin
            total++; if (att_at[i] !== i) $display("FAIL to_att_at_pulse%0d: got %0d want %0d", i, att_at[i], i); else passed++;
        end
        for (int i = 0; i < gaps.size(); i++) begin
            total++; if (gaps[i] !== TO_C) $display("FAIL to_wait_len%0d: got %0d want %0d", i, gaps[i], TO_C); else passed++;
        end
        total++; if (attempts !== 4'd3 || error !== 1'b1) $display("FAIL to_final: got att %0d err %b want 3/1", attempts, error); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL to_model: got %h want %h", dut_vec, m_vec); else passed++;
        gt_reset_done = 6'h3F;
        tick(300);
        total++; if (error !== 1'b1 || busy !== 1'b0 || serdes_rst !== 6'h3F) $display("FAIL fail_hold: got err %b busy %b serdes %h", error, busy, serdes_rst); else passed++;
    endtask

    task automatic test_empty_mask;
        pulse_start(6'h00);
        total++; if (error !== 1'b1 || attempts !== 4'd0 || busy !== 1'b0) $display("FAIL empty_mask: got err %b att %0d busy %b want 1/0/0", error, attempts, busy); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL empty_model: got %h want %h", dut_vec, m_vec); else passed++;
    endtask

    task automatic test_unmasked;
        gt_reset_done = 6'h01;
        pulse_start(6'h01);
        total++; if (error !== 1'b0 || busy !== 1'b1) $display("FAIL unm_start: got err %b busy %b want 0/1", error, busy); else passed++;
        wait_link(3000);
        total++; if (serdes_rst !== 6'h3E || link_up !== 1'b1) $display("FAIL unm_run: got %h/%b want 3e/1", serdes_rst, link_up); else passed++;
        for (int i = 0; i < 20; i++) begin
            gt_reset_done = 6'h01 | (6'($urandom) & 6'h3E);
            tick(1);
            total++; if (link_up !== 1'b1 || serdes_rst !== 6'h3E) $display("FAIL unm_toggle%0d: got %b/%h want 1/3e", i, link_up, serdes_rst); else passed++;
        end
        gt_reset_done = 6'h01;
        tick(1);
    endtask

    task automatic test_lock_loss;
        gt_reset_done = 6'h00;
        tick(1);
        total++; if (serdes_rst !== 6'h3F || link_up !== 1'b0 || gt_reset !== 1'b1) $display("FAIL lock_drop: got %h/%b/%b want 3f/0/1", serdes_rst, link_up, gt_reset); else passed++;
        tick($urandom_range(1, 10));
        gt_reset_done = 6'h01;
        wait_link(3000);
        total++; if (link_up !== 1'b1 || attempts !== 4'd0) $display("FAIL lock_relock: got link %b att %0d want 1/0", link_up, attempts); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL lock_model: got %h want %h", dut_vec, m_vec); else passed++;
    endtask

    task automatic test_power_drop;
        logic [5:0] m;
        int n = 0;
        m = 6'($urandom_range(1, 63));
        gt_reset_done = 6'h00;
        pulse_start(m);
        while (!gt_reset && n < 50) begin tick(1); n++; end
        n = 0;
        while (gt_reset && n < 50) begin tick(1); n++; end
        gt_reset_done = m | 6'($urandom);
        tick($urandom_range(10, 500));
        gt_pwr_good = 1'b0;
        tick(1);
        total++; if (busy !== 1'b1 || gt_reset !== 1'b0 || link_up !== 1'b0 || serdes_rst !== 6'h3F) $display("FAIL pwr_drop: got busy %b gt %b link %b serdes %h", busy, gt_reset, link_up, serdes_rst); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL pwr_drop_model: got %h want %h", dut_vec, m_vec); else passed++;
        tick(TO_C + 50);
        total++; if (busy !== 1'b1 || gt_reset !== 1'b0 || attempts !== 4'd0) $display("FAIL pwr_no_timeout: got busy %b gt %b att %0d", busy, gt_reset, attempts); else passed++;
        gt_reset_done = 6'h00;
        gt_pwr_good = 1'b1;
        tick(1);
        total++; if (gt_reset !== 1'b1) $display("FAIL pwr_restore_rst: got %b want 1", gt_reset); else passed++;
        n = 0;
        while (gt_reset && n < 50) begin tick(1); n++; end
        // Done arrives on the very cycle the wait would time out.
        tick(TO_C - 1);
        gt_reset_done = m;
        tick(1);
        total++; if (gt_reset !== 1'b0 || busy !== 1'b1 || attempts !== 4'd0) $display("FAIL pwr_done_wins: got gt %b busy %b att %0d want 0/1/0", gt_reset, busy, attempts); else passed++;
        total++; if (dut_vec !== m_vec) $display("FAIL pwr_tie_model: got %h want %h", dut_vec, m_vec); else passed++;
        wait_link(3000);
        total++; if (serdes_rst !== ~m || link_up !== 1'b1) $display("FAIL pwr_run: got %h/%b want %h/1", serdes_rst, link_up, ~m); else passed++;
    endtask

    task automatic test_async_reset;
        int n = 0;
        gt_reset_done = 6'h00;
        pulse_start(6'h03);
        while (attempts !== 4'd1 && n < 1000) begin tick(1); n++; end
        n = 0;
        while (gt_reset && n < 50) begin tick(1); n++; end
        tick(5);
        #2 aresetn = 1'b0;
        #1;
        total++; if (dut_vec !== RESET_VEC) $display("FAIL areset_imm: got %h want %h", dut_vec, RESET_VEC); else passed++;
        tick(1);
        total++; if (dut_vec !== m_vec) $display("FAIL areset_model: got %h want %h", dut_vec, m_vec); else passed++;
        aresetn = 1'b1;
        tick(3);
        total++; if (dut_vec !== RESET_VEC) $display("FAIL areset_no_resume: got %h want %h", dut_vec, RESET_VEC); else passed++;
        gt_reset_done = 6'h03;
        pulse_start(6'h03);
        total++; if (busy !== 1'b1 || attempts !== 4'd0) $display("FAIL areset_restart: got busy %b att %0d want 1/0", busy, attempts); else passed++;
        wait_link(3000);
        total++; if (serdes_rst !== 6'h3C || attempts !== 4'd0) $display("FAIL areset_run: got %h att %0d want 3c/0", serdes_rst, attempts); else passed++;
    endtask

    task automatic test_random;
        for (int blk = 0; blk < 6; blk++) begin
            int mode = $urandom_range(0, 1);
            for (int c = 0; c < 200; c++) begin
                total++; if (dut_vec !== m_vec) $display("FAIL rand_b%0d_c%0d: got %h want %h", blk, c, dut_vec, m_vec); else passed++;
                start       = ($urandom_range(0, 59) == 0);
                lane_mask   = 6'($urandom);
                gt_pwr_good = ($urandom_range(0, 149) != 0);
                if (mode == 0) gt_reset_done = 6'($urandom);
                else gt_reset_done = ($urandom_range(0, 299) == 0) ? 6'($urandom) : 6'h3F;
                tick(1);
            end
        end
        start = 1'b0;
        gt_pwr_good = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_empty_mask();
        test_unmasked();
        test_lock_loss();
        test_power_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
